brushless_cmt: RTL

//  Parametrised BLDC commutation controller, successor to the fixed 3-hall commutator.

---
 rtl/brushless_pkg.sv | 56 +++++
 rtl/hall_filt.sv | 67 ++++++
 rtl/brushless_cmt.sv | 134 +++++++++++++
 3 files changed

// File: rtl/brushless_pkg.sv
// Shared types and the commutation lookup for the BLDC commutation controller.
package brushless_pkg;

  typedef enum logic [1:0] {
    SEL_HIZ   = 2'b00,
    SEL_REV   = 2'b01,
    SEL_FWD   = 2'b10,
    SEL_REGEN = 2'b11
  } sel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BRAKE,
    ST_FAULT
  } cmt_state_t;

  typedef struct packed {
    sel_t grn;
    sel_t ylw;
    sel_t blu;
  } sel_set_t;

  function automatic logic sect_valid(input logic [2:0] sect);
    return (sect != 3'b000) && (sect != 3'b111);
  endfunction

  function automatic sel_t swap_dir(input sel_t s);
    case (s)
      SEL_REV: return SEL_FWD;
      SEL_FWD: return SEL_REV;
      default: return s;
    endcase
  endfunction

  // Forward table; reverse is the same with REV/FWD exchanged on every coil.
  function automatic sel_set_t cmt_lookup(input logic [2:0] sect, input logic dir);
    sel_set_t s;
    case (sect)
      3'b001:  s = '{SEL_HIZ, SEL_REV, SEL_FWD};
      3'b010:  s = '{SEL_REV, SEL_FWD, SEL_HIZ};
      3'b011:  s = '{SEL_REV, SEL_HIZ, SEL_FWD};
      3'b100:  s = '{SEL_FWD, SEL_HIZ, SEL_REV};
      3'b101:  s = '{SEL_FWD, SEL_REV, SEL_HIZ};
      3'b110:  s = '{SEL_HIZ, SEL_FWD, SEL_REV};
      default: s = '{SEL_HIZ, SEL_HIZ, SEL_HIZ};
    endcase
    if (!dir) begin
      s.grn = swap_dir(s.grn);
      s.ylw = swap_dir(s.ylw);
      s.blu = swap_dir(s.blu);
    end
    return s;
  endfunction

endpackage

// File: rtl/hall_filt.sv
// Hall sensor synchroniser and deglitch filter; h_f only follows vectors held
// stable for FILT_CNT clocks, with a one-clock accept pulse on each change.
module hall_filt #(
  parameter int unsigned FILT_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] h_raw,
  output logic [2:0] h_f,
  output logic       accept,
  output logic       h_vld
);

  localparam int unsigned CNT_W = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]       cand_q, cand_d, hf_q, hf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d, vld_q, vld_d;

  always_comb begin
    sync1_d = h_raw;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    hf_d    = hf_q;
    acc_d   = 1'b0;
    vld_d   = vld_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
    if ((cnt_q == CNT_LAST) && (cand_q != hf_q)) begin
      hf_d  = cand_q;
      acc_d = 1'b1;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      hf_q    <= '0;
      acc_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      hf_q    <= hf_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
    end
  end

  assign h_f    = hf_q;
  assign accept = acc_q;
  assign h_vld  = vld_q;

endmodule

// File: rtl/brushless_cmt.sv
// BLDC commutation controller: sector latch, run/brake/fault FSM, coil select,
// duty word and commutation-period measurement.
module brushless_cmt
  import brushless_pkg::*;
#(
  parameter int unsigned       DRV_W      = 12,
  parameter int unsigned       DUTY_W     = 11,
  parameter int unsigned       FILT_CNT   = 4,
  parameter logic [DUTY_W-1:0] BRAKE_DUTY = 11'h600,
  parameter int unsigned       PER_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hallGrn,
  input  logic              hallYlw,
  input  logic              hallBlu,
  input  logic              en,
  input  logic              dir,
  input  logic              brake_n,
  input  logic              PWM_synch,
  input  logic [DRV_W-1:0]  drv_mag,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        selGrn,
  output logic [1:0]        selYlw,
  output logic [1:0]        selBlu,
  output logic [PER_W-1:0]  comm_period,
  output logic              comm_vld,
  output logic              fault
);

  localparam logic [DUTY_W-1:0] DUTY_MID = {1'b1, {(DUTY_W-1){1'b0}}};
  localparam sel_set_t SEL_OFF = '{SEL_HIZ, SEL_HIZ, SEL_HIZ};
  localparam sel_set_t SEL_BRK = '{SEL_REGEN, SEL_REGEN, SEL_REGEN};

  logic [2:0]        h_f;
  logic              accept, h_vld;
  logic [DUTY_W-1:0] duty_run;
  logic              drv_lsb_unused;

  cmt_state_t        state_q, state_d;
  logic [2:0]        sect_q, sect_d;
  logic              sect_vld_q, sect_vld_d;
  sel_set_t          sel_q, sel_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [PER_W-1:0]  pcnt_q, pcnt_d, pcnt_inc;
  logic [PER_W-1:0]  comm_period_q, comm_period_d;
  logic              comm_vld_q, comm_vld_d, fault_q, fault_d;
  logic              stall, sect_bad;

  hall_filt #(.FILT_CNT(FILT_CNT)) u_hall_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .h_raw  ({hallGrn, hallYlw, hallBlu}),
    .h_f    (h_f),
    .accept (accept),
    .h_vld  (h_vld)
  );

  assign duty_run       = {1'b0, drv_mag[DRV_W-1:2]} + DUTY_MID;
  assign drv_lsb_unused = ^drv_mag[1:0];

  always_comb begin
    sect_d     = PWM_synch ? h_f : sect_q;
    sect_vld_d = sect_vld_q | (PWM_synch & h_vld);
    stall      = (pcnt_q == '1);
    pcnt_inc   = stall ? pcnt_q : pcnt_q + 1'b1;
    // Period latches the incremented count so the clearing clock is included.
    pcnt_d        = accept ? '0 : pcnt_inc;
    comm_period_d = accept ? pcnt_inc : comm_period_q;
    comm_vld_d    = accept;
    // The power-up all-zero sector is not a fault until a real sector is latched.
    sect_bad = sect_vld_q & ~sect_valid(sect_q);

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (en) state_d = brake_n ? ST_RUN : ST_BRAKE;
      ST_RUN:   if (!en) state_d = ST_IDLE;
                else if (sect_bad || stall) state_d = ST_FAULT;
                else if (!brake_n) state_d = ST_BRAKE;
      ST_BRAKE: if (!en) state_d = ST_IDLE;
                else if (brake_n) state_d = ST_RUN;
      ST_FAULT: if (!en) state_d = ST_IDLE;
    endcase
    fault_d = (state_d == ST_FAULT);

    sel_d  = sel_q;
    duty_d = duty_q;
    if ((state_d == ST_IDLE) || (state_d == ST_FAULT)) begin
      sel_d  = SEL_OFF;
      duty_d = '0;
    end else if (PWM_synch) begin
      if (state_d == ST_BRAKE) begin
        sel_d  = SEL_BRK;
        duty_d = BRAKE_DUTY;
      end else begin
        sel_d  = cmt_lookup(sect_d, dir);
        duty_d = sect_valid(sect_d) ? duty_run : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sect_q        <= '0;
      sect_vld_q    <= 1'b0;
      sel_q         <= SEL_OFF;
      duty_q        <= '0;
      pcnt_q        <= '0;
      comm_period_q <= '0;
      comm_vld_q    <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sect_q        <= sect_d;
      sect_vld_q    <= sect_vld_d;
      sel_q         <= sel_d;
      duty_q        <= duty_d;
      pcnt_q        <= pcnt_d;
      comm_period_q <= comm_period_d;
      comm_vld_q    <= comm_vld_d;
      fault_q       <= fault_d;
    end
  end

  assign selGrn      = sel_q.grn;
  assign selYlw      = sel_q.ylw;
  assign selBlu      = sel_q.blu;
  assign duty        = duty_q;
  assign comm_period = comm_period_q;
  assign comm_vld    = comm_vld_q;
  assign fault       = fault_q;

endmodule
